// File: rtl/hamming_secded_decoder.sv
// SECDED decoder that masters a shared byte-wide data memory: reads 16-bit codewords,
// corrects single errors, flags double errors, and writes 11-bit data plus 2-bit status.
module hamming_secded_decoder #(
    parameter int ADDR_W    = 8,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int NUM_WORDS = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [6:0]        n_single,
    output logic [6:0]        n_double
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DEC, WR_LO, WR_HI, DONE} state_t;

    localparam logic [6:0] LAST = 7'(NUM_WORDS - 1);

    state_t      state, state_nxt;
    logic [6:0]  idx;
    logic [15:0] cw;
    logic [15:0] fixed;
    logic [1:0]  flag;
    logic [3:0]  syn;
    logic        par;
    logic [ADDR_W-1:0] offs;

    assign offs = ADDR_W'({idx, 1'b0});

    always_comb begin
        syn = '0;
        for (int k = 1; k < 16; k++)
            if (cw[k]) syn = syn ^ 4'(k);
        par = ^cw;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RD_LO;
            RD_LO:      state_nxt = RD_HI;
            RD_HI:      state_nxt = DEC;
            DEC:        state_nxt = WR_LO;
            WR_LO:      state_nxt = WR_HI;
            WR_HI:      state_nxt = (idx == LAST) ? DONE : RD_LO;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx      <= '0;
            cw       <= '0;
            fixed    <= '0;
            flag     <= '0;
            n_single <= '0;
            n_double <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    idx      <= '0;
                    n_single <= '0;
                    n_double <= '0;
                end
                RD_LO: cw[7:0]  <= mem_rd_data;
                RD_HI: cw[15:8] <= mem_rd_data;
                DEC: begin
                    // Odd overall parity means one flip; syn==0 points at p0, leaving data intact.
                    if (par) begin
                        fixed <= cw ^ (16'd1 << syn);
                        flag  <= 2'b01;
                        if (n_single != 7'd127) n_single <= n_single + 7'd1;
                    end else if (syn != 4'd0) begin
                        fixed <= cw;
                        flag  <= 2'b10;
                        if (n_double != 7'd127) n_double <= n_double + 7'd1;
                    end else begin
                        fixed <= cw;
                        flag  <= 2'b00;
                    end
                end
                WR_HI: if (idx != LAST) idx <= idx + 7'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        done        = (state == DONE);
        busy        = (state != IDLE) && (state != DONE);
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            RD_LO: mem_addr = ADDR_W'(SRC_BASE) + offs;
            RD_HI: mem_addr = ADDR_W'(SRC_BASE) + offs + ADDR_W'(1);
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(DST_BASE) + offs;
                mem_wr_data = {fixed[12:9], fixed[7:5], fixed[3]};
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(DST_BASE) + offs + ADDR_W'(1);
                mem_wr_data = {flag, 3'b000, fixed[15:13]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized bench for hamming_secded_decoder: byte memory model plus a Hamming
// encode/flip reference that predicts every decoded pair and the error counters.
module tb_hamming_secded_decoder;

    localparam int ADDR_W = 8;
    localparam int SRC    = 30;
    localparam int DST    = 0;
    localparam int NW     = 15;

    logic              clk = 0;
    logic              reset = 0;
    logic              start = 0;
    logic              done, busy, mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data, mem_wr_data;
    logic [6:0]        n_single, n_double;

    logic [7:0]  mem [256];
    logic [15:0] src_cw [NW];
    logic [7:0]  exp_lo [NW];
    logic [7:0]  exp_hi [NW];
    int          exp_s, exp_d;
    int          errors = 0;
    int          checks = 0;

    hamming_secded_decoder #(.ADDR_W(ADDR_W), .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .n_single(n_single), .n_double(n_double)
    );

    always #5 clk = ~clk;
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] c = '0;
        for (int j = 0; j < 11; j++) c[dpos[j]] = d[j];
        for (int p = 1; p <= 8; p = p * 2)
            for (int k = 1; k < 16; k++)
                if ((k & p) != 0 && k != p) c[p] = c[p] ^ c[k];
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = c[dpos[j]];
        return d;
    endfunction

    task automatic set_exp(input int w, input logic [10:0] d, input logic [1:0] f);
        exp_lo[w] = d[7:0];
        exp_hi[w] = {f, 3'b000, d[10:8]};
    endtask

    task automatic gen_random();
        exp_s = 0; exp_d = 0;
        for (int w = 0; w < NW; w++) begin
            logic [10:0] d = 11'($urandom);
            logic [15:0] c = encode(d);
            int nf = $urandom_range(0, 2);
            int p1 = $urandom_range(0, 15);
            int p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
            if (nf >= 1) c[p1] = ~c[p1];
            if (nf == 2) c[p2] = ~c[p2];
            src_cw[w] = c;
            if (nf == 0) set_exp(w, d, 2'b00);
            else if (nf == 1) begin set_exp(w, d, 2'b01); exp_s++; end
            else begin set_exp(w, extract(c), 2'b10); exp_d++; end
        end
    endtask

    task automatic run_job(input string name, input bit poke_start);
        int edges;
        for (int w = 0; w < NW; w++) begin
            mem[SRC + 2*w]     = src_cw[w][7:0];
            mem[SRC + 2*w + 1] = src_cw[w][15:8];
            mem[DST + 2*w]     = 8'hA5;
            mem[DST + 2*w + 1] = 8'hA5;
        end
        @(negedge clk); start = 1;
        @(posedge clk); edges = 1; #1; start = 0;
        while (!done && edges < 2000) begin
            if (poke_start && edges == 10) start = 1;
            if (poke_start && edges == 11) start = 0;
            @(posedge clk); edges++; #1;
        end
        chk({name, " done_edge"}, edges, 5*NW + 1);
        for (int w = 0; w < NW; w++) begin
            chk($sformatf("%s lo[%0d]", name, w), int'(mem[DST + 2*w]), int'(exp_lo[w]));
            chk($sformatf("%s hi[%0d]", name, w), int'(mem[DST + 2*w + 1]), int'(exp_hi[w]));
        end
        chk({name, " n_single"}, int'(n_single), exp_s);
        chk({name, " n_double"}, int'(n_double), exp_d);
        chk({name, " busy_done"}, int'(busy), 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", int'(done), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst wr_en", int'(mem_wr_en), 0);
        chk("rst addr", int'(mem_addr), 0);
        chk("rst wr_data", int'(mem_wr_data), 0);
        chk("rst n_single", int'(n_single), 0);
        chk("rst n_double", int'(n_double), 0);
        @(negedge clk); reset = 1;

        // All-zero codewords
        for (int w = 0; w < NW; w++) begin src_cw[w] = 16'h0000; set_exp(w, 11'd0, 2'b00); end
        exp_s = 0; exp_d = 0;
        run_job("zero", 1'b0);

        // Directed single/double corner words
        src_cw[0] = 16'h0200; exp_lo[0] = 8'h00; exp_hi[0] = 8'h40;
        src_cw[1] = 16'h7FFF; exp_lo[1] = 8'hFF; exp_hi[1] = 8'h47;
        src_cw[2] = 16'h0001; exp_lo[2] = 8'h00; exp_hi[2] = 8'h40;
        src_cw[3] = 16'h0003; exp_lo[3] = 8'h00; exp_hi[3] = 8'h80;
        exp_s = 3; exp_d = 1;
        run_job("directed", 1'b0);
        repeat (3) @(negedge clk);
        chk("hold n_single", int'(n_single), 3);
        chk("hold done", int'(done), 1);

        for (int r = 0; r < 3; r++) begin
            gen_random();
            run_job($sformatf("rand%0d", r), r == 1);
        end

        // Mid-run reset aborts immediately
        gen_random();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (19) @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort wr_en", int'(mem_wr_en), 0);
        chk("abort n_single", int'(n_single), 0);
        @(negedge clk); reset = 1;
        run_job("after_rst", 1'b0);

        // Rerun from DONE clears counters
        for (int w = 0; w < NW; w++) begin src_cw[w] = 16'h0000; set_exp(w, 11'd0, 2'b00); end
        exp_s = 0; exp_d = 0;
        run_job("rerun", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
